// File: rtl/spi_frame_buffer.sv
// rtl/spi_frame_buffer.sv - double-buffered COLS x ROWS character frame store fed by an SPI byte receiver
// A frame is committed to the front bank only when a message delivers exactly one full frame.
module spi_frame_buffer #(
  parameter int COLS   = 40,
  parameter int ROWS   = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msg_start,
  input  logic              msg_end,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  input  logic [5:0]        rd_col,
  input  logic [3:0]        rd_row,
  output logic [DATA_W-1:0] rd_data,
  output logic              front_bank,
  output logic              frame_swap,
  output logic              short_frame,
  output logic              overflow,
  output logic              busy
);

  localparam int FRAME = COLS * ROWS;
  localparam int DEPTH = 2 * FRAME;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, RECV, FULL, DISCARD} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              front_q, front_d;
  logic              swap_q, swap_d;
  logic              short_q, short_d;
  logic              ovf_q, ovf_d;
  logic              we;
  logic              last_col;
  logic              last_cell;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;
  logic              rd_oob;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem [DEPTH];

  assign last_col  = (col_q == CW'(COLS - 1));
  assign last_cell = last_col && (row_q == RW'(ROWS - 1));

  // Writes always land in the bank opposite the one being displayed.
  assign wr_addr = (front_q ? AW'(0) : AW'(FRAME)) + AW'(row_q) * AW'(COLS) + AW'(col_q);
  assign rd_addr = (front_q ? AW'(FRAME) : AW'(0)) + AW'(rd_row) * AW'(COLS) + AW'(rd_col);
  assign rd_oob  = (32'(rd_col) >= COLS) || (32'(rd_row) >= ROWS);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    front_d = front_q;
    swap_d  = 1'b0;
    short_d = 1'b0;
    ovf_d   = 1'b0;
    we      = 1'b0;
    if (msg_start) begin
      // A new message always restarts the back bank; an open one counts as aborted.
      state_d = RECV;
      col_d   = '0;
      row_d   = '0;
      short_d = (state_q == RECV);
    end else begin
      case (state_q)
        RECV: begin
          if (byte_valid) begin
            we = 1'b1;
            if (last_col) begin
              col_d = '0;
              row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
          if (msg_end) begin
            state_d = IDLE;
            if (byte_valid && last_cell) begin
              swap_d  = 1'b1;
              front_d = ~front_q;
            end else begin
              short_d = 1'b1;
            end
          end else if (byte_valid && last_cell) begin
            state_d = FULL;
          end
        end
        FULL: begin
          if (byte_valid) begin
            ovf_d   = 1'b1;
            state_d = msg_end ? IDLE : DISCARD;
          end else if (msg_end) begin
            swap_d  = 1'b1;
            front_d = ~front_q;
            state_d = IDLE;
          end
        end
        DISCARD: begin
          if (msg_end) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      front_q <= 1'b0;
      swap_q  <= 1'b0;
      short_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      front_q <= front_d;
      swap_q  <= swap_d;
      short_q <= short_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem[wr_addr] <= byte_data;
  end

  always_ff @(posedge clk) begin
    if (rst || rd_oob) rd_data_q <= '0;
    else               rd_data_q <= mem[rd_addr];
  end

  assign rd_data     = rd_data_q;
  assign front_bank  = front_q;
  assign frame_swap  = swap_q;
  assign short_frame = short_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q != IDLE);

endmodule
